// File: rtl/divsqrt_issue_ctrl.sv
// Issue controller for the shared divide/square-root datapath.
// Two requesters are arbitrated round-robin, and at most one operation is issued
// per cycle into a fixed-latency datapath. A tag delay line tracks the operations
// in flight. Results come back through a response FIFO, and credits make sure
// that FIFO can never overflow.
module divsqrt_issue_ctrl #(
   parameter int LAT        = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [3:0]  req_opcode,
   input  logic [1:0]  req_fmt,
   input  logic [63:0] req_x,
   input  logic [63:0] req_y,
   output logic [1:0]  dp_opcode,
   output logic        dp_fmt,
   output logic [31:0] dp_x,
   output logic [31:0] dp_y,
   input  logic [31:0] dp_r,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_data,
   output logic        busy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW:0]   DEPTH_OCC = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_PTR  = PW'(FIFO_DEPTH - 1);

   logic [CW-1:0] inflight_cnt;
   logic [CW-1:0] fifo_cnt;
   logic [CW:0]   occupancy;
   logic          credit_ok;
   logic          prio;
   logic [1:0]    grant;
   logic          gnt_id;
   logic          issue;
   logic [LAT-1:0] dl_v;
   logic [LAT-1:0] dl_tag;
   logic          retire;
   logic          push;
   logic          pop;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [32:0]   mem [FIFO_DEPTH];
   logic [32:0]   head;

   // Wraps a FIFO pointer at the depth, which does not have to be a power of two.
   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Credits: every in-flight op has a FIFO slot reserved for it. A pop frees
   // its slot only from the next cycle on, because this uses register values.
   always_comb begin
      occupancy = {1'b0, inflight_cnt} + {1'b0, fifo_cnt};
      credit_ok = occupancy < DEPTH_OCC;
   end

   // Round-robin grant. It is held at zero while reset is asserted, so that
   // req_ready drops at once.
   always_comb begin
      grant  = 2'b00;
      gnt_id = 1'b0;
      if (rst_n && credit_ok) begin
         if (req_valid[prio]) begin
            grant[prio] = 1'b1;
            gnt_id      = prio;
         end else if (req_valid[~prio]) begin
            grant[~prio] = 1'b1;
            gnt_id       = ~prio;
         end
      end
   end

   assign req_ready = grant;
   assign issue     = |grant;
   assign retire    = dl_v[LAT-1];
   assign push      = retire;
   assign pop       = rsp_valid & rsp_ready;

   // Datapath operand registers and priority pointer; both change only on an issue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio      <= 1'b0;
         dp_opcode <= 2'b00;
         dp_fmt    <= 1'b0;
         dp_x      <= 32'h0;
         dp_y      <= 32'h0;
      end else if (issue) begin
         prio      <= ~gnt_id;
         dp_opcode <= gnt_id ? req_opcode[3:2] : req_opcode[1:0];
         dp_fmt    <= req_fmt[gnt_id];
         dp_x      <= gnt_id ? req_x[63:32] : req_x[31:0];
         dp_y      <= gnt_id ? req_y[63:32] : req_y[31:0];
      end
   end

   // Tag delay line, shifted every cycle. The last stage lines up with dp_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dl_v   <= '0;
         dl_tag <= '0;
      end else begin
         for (int s = LAT - 1; s > 0; s--) begin
            dl_v[s]   <= dl_v[s-1];
            dl_tag[s] <= dl_tag[s-1];
         end
         dl_v[0]   <= issue;
         dl_tag[0] <= issue & gnt_id;
      end
   end

   // Occupancy counters for the in-flight ops and the FIFO entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inflight_cnt <= '0;
         fifo_cnt     <= '0;
      end else begin
         case ({issue, retire})
            2'b10:   inflight_cnt <= inflight_cnt + CW'(1);
            2'b01:   inflight_cnt <= inflight_cnt - CW'(1);
            default: inflight_cnt <= inflight_cnt;
         endcase
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // FIFO read and write pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
      end
   end

   // FIFO storage. It has no reset, because entries are visible only through fifo_cnt.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {dl_tag[LAT-1], dp_r};
   end

   // Head of the FIFO, forced to zero when the FIFO is empty.
   always_comb begin
      head      = mem[rd_ptr];
      rsp_valid = (fifo_cnt != '0);
      rsp_id    = rsp_valid & head[32];
      rsp_data  = rsp_valid ? head[31:0] : 32'h0;
      busy      = (inflight_cnt != '0) | rsp_valid;
   end

   // Credits reserve a slot for every op before it issues, so a full FIFO can never see a push.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (fifo_cnt == FULL_CNT)));

endmodule

// File: tb/tb_divsqrt_issue_ctrl.sv
// Testbench for divsqrt_issue_ctrl. A datapath stub returns dp_x ^ dp_y LAT
// edges after the issue. Expected responses are queued when an accept is
// expected, and a negedge monitor pops the queue and compares on each response.
module tb_divsqrt_issue_ctrl;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req_opcode;
   logic [1:0]  req_fmt;
   logic [63:0] req_x;
   logic [63:0] req_y;
   logic [1:0]  dp_opcode;
   logic        dp_fmt;
   logic [31:0] dp_x;
   logic [31:0] dp_y;
   logic [31:0] dp_r;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic        busy;

   logic [31:0] x0, y0, x1, y1;
   logic [1:0]  op0, op1;
   logic        f0, f1;
   logic [31:0] p1, p2;

   int          checks = 0;
   int          errors = 0;
   int          n0 = 0;
   int          n1 = 0;
   logic [32:0] sb [$];

   // Expected grant per cycle, from idle, with rsp_ready high:
   // four issues, one credit stall, then four more issues.
   logic [1:0] t2_exp [9] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
   logic [1:0] t4_exp [9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01};

   assign req_x      = {x1, x0};
   assign req_y      = {y1, y0};
   assign req_opcode = {op1, op0};
   assign req_fmt    = {f1, f0};

   divsqrt_issue_ctrl #(.LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_fmt(req_fmt), .req_x(req_x), .req_y(req_y),
      .dp_opcode(dp_opcode), .dp_fmt(dp_fmt), .dp_x(dp_x), .dp_y(dp_y), .dp_r(dp_r),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Datapath stub: two register stages, so dp_r is valid at edge E+3.
   always @(posedge clk) begin
      p1 <= dp_x ^ dp_y;
      p2 <= p1;
   end
   assign dp_r = p2;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one cycle of requests and checks the grant. The expected response
   // is queued for the requester the bench expects to win.
   task automatic cyc(input logic [1:0] v, input logic [1:0] exp);
      req_valid = v;
      x0  = 32'hA000_0000 | 32'(n0);
      y0  = 32'h0000_5A5A + (32'(n0) << 8);
      x1  = 32'hB500_0000 | (32'(n1) * 32'h0001_0001);
      y1  = 32'h0F0F_0000 ^ 32'(n1);
      op0 = 2'(n0);
      op1 = 2'(n1);
      f0  = n0[0];
      f1  = n1[0];
      #1;
      chk("req_ready", {62'b0, req_ready}, {62'b0, exp});
      if (exp[0]) begin
         sb.push_back({1'b0, x0 ^ y0});
         n0++;
      end
      if (exp[1]) begin
         sb.push_back({1'b1, x1 ^ y1});
         n1++;
      end
      tick();
   endtask

   task automatic drain(input string nm);
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      for (int k = 0; k < 60 && busy; k++) tick();
      chk({nm, "_idle"}, {63'b0, busy}, 64'd0);
      chk({nm, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   // Response monitor. Stale or unexpected responses, and data mismatches, are errors.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else if (rsp_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data %h expected no response", rsp_id, rsp_data);
         end else if (rsp_ready) begin
            logic [32:0] e;
            e = sb.pop_front();
            chk("rsp_id_data", {31'b0, rsp_id, rsp_data}, {31'b0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b0;
      x0 = 32'h1; y0 = 32'h2; x1 = 32'h3; y1 = 32'h4;
      op0 = 2'd3; op1 = 2'd3; f0 = 1'b1; f1 = 1'b1;
      tick();
      tick();
      chk("rst_req_ready", {62'b0, req_ready}, 64'd0);
      chk("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      chk("rst_rsp_id", {63'b0, rsp_id}, 64'd0);
      chk("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      chk("rst_dp_x", {32'b0, dp_x}, 64'd0);
      chk("rst_dp_opcode", {62'b0, dp_opcode}, 64'd0);
      req_valid = 2'b00;
      rst_n = 1'b1;
      tick();

      // Single op from requester 0
      req_valid = 2'b01;
      x0 = 32'h4040_0000; y0 = 32'h3F80_0000; op0 = 2'd1; f0 = 1'b0;
      #1;
      chk("t1_ready", {62'b0, req_ready}, 64'h1);
      sb.push_back({1'b0, 32'h7FC0_0000});
      tick();
      req_valid = 2'b00;
      chk("t1_dp_x", {32'b0, dp_x}, 64'h4040_0000);
      chk("t1_dp_y", {32'b0, dp_y}, 64'h3F80_0000);
      chk("t1_dp_opcode", {62'b0, dp_opcode}, 64'd1);
      chk("t1_dp_fmt", {63'b0, dp_fmt}, 64'd0);
      chk("t1_busy", {63'b0, busy}, 64'd1);
      chk("t1_rsp_e0", {63'b0, rsp_valid}, 64'd0);
      tick();
      chk("t1_rsp_e1", {63'b0, rsp_valid}, 64'd0);
      tick();
      chk("t1_rsp_e2", {63'b0, rsp_valid}, 64'd0);
      tick();
      chk("t1_rsp_e3", {63'b0, rsp_valid}, 64'd1);
      chk("t1_rsp_id", {63'b0, rsp_id}, 64'd0);
      chk("t1_rsp_data", {32'b0, rsp_data}, 64'h7FC0_0000);
      rsp_ready = 1'b1;
      tick();
      chk("t1_rsp_popped", {63'b0, rsp_valid}, 64'd0);
      chk("t1_busy_done", {63'b0, busy}, 64'd0);

      // Single op from requester 1; afterwards requester 0 holds priority
      cyc(2'b10, 2'b10);
      drain("t1b");

      // Round-robin with both requesters valid
      for (int k = 0; k < 9; k++) cyc(2'b11, t2_exp[k]);
      drain("t2");

      // Credit stall with rsp_ready low
      rsp_ready = 1'b0;
      for (int k = 0; k < 10; k++) cyc(2'b10, (k < 4) ? 2'b10 : 2'b00);
      chk("t3_fifo_full", 64'(dut.fifo_cnt), 64'd4);
      rsp_ready = 1'b1;
      cyc(2'b10, 2'b00);
      rsp_ready = 1'b0;
      cyc(2'b10, 2'b10);
      cyc(2'b10, 2'b00);
      cyc(2'b10, 2'b00);
      drain("t3");

      // Streaming with simultaneous push and pop
      for (int k = 0; k < 9; k++) begin
         cyc(2'b01, t4_exp[k]);
         chk("t4_fifo_le1", {63'b0, (dut.fifo_cnt <= 1)}, 64'd1);
      end
      drain("t4");

      // Reset mid-operation: 2 ops in flight, 1 queued
      rsp_ready = 1'b0;
      cyc(2'b01, 2'b01);
      cyc(2'b01, 2'b01);
      cyc(2'b01, 2'b01);
      cyc(2'b00, 2'b00);
      chk("t5_pre_rsp_valid", {63'b0, rsp_valid}, 64'd1);
      chk("t5_pre_busy", {63'b0, busy}, 64'd1);
      req_valid = 2'b11;
      #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      chk("t5_rst_busy", {63'b0, busy}, 64'd0);
      chk("t5_rst_req_ready", {62'b0, req_ready}, 64'd0);
      chk("t5_rst_rsp_data", {32'b0, rsp_data}, 64'd0);
      tick();
      tick();
      chk("t5_rst_dp_x", {32'b0, dp_x}, 64'd0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      #1;
      chk("t5_post_rsp_valid", {63'b0, rsp_valid}, 64'd0);
      chk("t5_post_busy", {63'b0, busy}, 64'd0);

      // First grant after reset goes to requester 0, then priority is held
      cyc(2'b11, 2'b01);
      chk("t6_no_stale0", {63'b0, rsp_valid}, 64'd0);
      cyc(2'b01, 2'b01);
      chk("t6_no_stale1", {63'b0, rsp_valid}, 64'd0);
      cyc(2'b01, 2'b01);
      chk("t6_no_stale2", {63'b0, rsp_valid}, 64'd0);
      cyc(2'b11, 2'b10);
      drain("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
